// File: rtl/fan_pkg.sv
// fan_pkg
// Shared constants for the fan controller time base.
//   CLK_FREQ_HZ   : system clock frequency in Hz
//   CYCLES_250MS  : clock cycles in one 250 ms interval at CLK_FREQ_HZ
//   cnt_width()   : counter width for a modulo-n counter (never below 1 bit)
package fan_pkg;

  localparam int CLK_FREQ_HZ  = 100_000_000;
  localparam int CYCLES_250MS = CLK_FREQ_HZ / 4;

  // A modulo-n counter holds 0..n-1, which needs $clog2(n) bits. The floor
  // of 1 keeps the declaration legal even for a degenerate n.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_tick_div.sv
// tick_div
// Modulo-DIV divider that flags every DIV-th enabled cycle.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, asserted HIGH despite the name
//   en    : count enable; the counter holds while low
//   tick  : high during the cycle in which an enabled edge will wrap the
//           counter, i.e. once every DIV enabled cycles. It is decoded from
//           the counter state, so users that need a clean flop output
//           register it themselves.
module tick_div
  import fan_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic         wrap;

  assign wrap = en && (cnt_reg == LAST);
  assign tick = wrap;

  always_comb begin
    cnt_next = cnt_reg;
    if (wrap) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/timer.sv
// timer
// Free-running time base: three aligned one-cycle strobes at 250 ms, 500 ms
// and 1 s, used downstream as clock enables.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous reset, asserted HIGH despite the name
//   timer_250ms : strobe once every TICK_250MS_CYCLES cycles
//   timer_500ms : strobe on every 2nd 250 ms strobe
//   timer_1s    : strobe on every 4th 250 ms strobe
// All three outputs come straight from flops.
module timer #(
  parameter int CLK_FREQ_HZ       = fan_pkg::CLK_FREQ_HZ,
  parameter int TICK_250MS_CYCLES = CLK_FREQ_HZ / 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic timer_250ms,
  output logic timer_500ms,
  output logic timer_1s
);

  logic       base_tick;
  logic [1:0] q_reg;
  logic [1:0] q_next;
  logic       timer_250ms_reg;
  logic       timer_500ms_reg;
  logic       timer_1s_reg;

  // Base count: wraps every TICK_250MS_CYCLES cycles, always enabled.
  tick_div #(
    .DIV (TICK_250MS_CYCLES)
  ) u_base_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .tick  (base_tick)
  );

  // Quarter count kept inline: its value (not just its wrap) selects the
  // 500 ms and 1 s strobes.
  always_comb begin
    q_next = q_reg;
    if (base_tick) begin
      q_next = q_reg + 2'd1;
    end
  end

  // q still holds the pre-wrap value on the wrap edge: q[0]==1 marks every
  // 2nd base wrap, q==3 every 4th, so all three strobes rise on the same edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q_reg           <= 2'd0;
      timer_250ms_reg <= 1'b0;
      timer_500ms_reg <= 1'b0;
      timer_1s_reg    <= 1'b0;
    end else begin
      q_reg           <= q_next;
      timer_250ms_reg <= base_tick;
      timer_500ms_reg <= base_tick && q_reg[0];
      timer_1s_reg    <= base_tick && (q_reg == 2'd3);
    end
  end

  assign timer_250ms = timer_250ms_reg;
  assign timer_500ms = timer_500ms_reg;
  assign timer_1s    = timer_1s_reg;

endmodule

// File: tb/tb_timer.sv
module tb_timer;

  localparam int NA = 5;
  localparam int NB = 2;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic a250, a500, a1s;
  logic b250, b500, b1s;

  int checks;
  int failures;

  // Model state: rising edges seen since the last reset release.
  longint ka;
  longint kb;
  int     pa250, pa500, pa1s;
  logic   prev_a250, prev_a500, prev_a1s;

  timer #(.TICK_250MS_CYCLES(NA)) dut_a (
    .clk         (clk),
    .rst_n       (rst_a),
    .timer_250ms (a250),
    .timer_500ms (a500),
    .timer_1s    (a1s)
  );

  timer #(.TICK_250MS_CYCLES(NB)) dut_b (
    .clk         (clk),
    .rst_n       (rst_b),
    .timer_250ms (b250),
    .timer_500ms (b500),
    .timer_1s    (b1s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Expected strobe after edge k of a divider with base period n and ratio m.
  function automatic logic exp_strobe(input longint k, input int n, input int m);
    return (k > 0) && ((k % (n * m)) == 0);
  endfunction

  // Advance one clock edge, update the model and compare both instances.
  task automatic step();
    @(posedge clk);
    if (!rst_a) ka++;
    if (!rst_b) kb++;
    #1;
    check("a_250ms", a250, exp_strobe(ka, NA, 1));
    check("a_500ms", a500, exp_strobe(ka, NA, 2));
    check("a_1s",    a1s,  exp_strobe(ka, NA, 4));
    check("b_250ms", b250, exp_strobe(kb, NB, 1));
    check("b_500ms", b500, exp_strobe(kb, NB, 2));
    check("b_1s",    b1s,  exp_strobe(kb, NB, 4));
    if (a1s)  check("align_1s_500",  a500, 1'b1);
    if (a1s)  check("align_1s_250",  a250, 1'b1);
    if (a500) check("align_500_250", a250, 1'b1);
    if (prev_a250) check("width_250ms", a250, 1'b0);
    if (prev_a500) check("width_500ms", a500, 1'b0);
    if (prev_a1s)  check("width_1s",    a1s,  1'b0);
    prev_a250 = a250;
    prev_a500 = a500;
    prev_a1s  = a1s;
    pa250 += int'(a250);
    pa500 += int'(a500);
    pa1s  += int'(a1s);
    $display("edge ka=%0d kb=%0d a=%0b%0b%0b b=%0b%0b%0b", ka, kb,
             a250, a500, a1s, b250, b500, b1s);
  endtask

  // Assert reset on instance A mid-cycle and confirm outputs drop at once.
  task automatic reset_a_now(input string tag);
    #1;
    rst_a = 1'b1;
    ka    = 0;
    #1;
    check({tag, "_250"}, a250, 1'b0);
    check({tag, "_500"}, a500, 1'b0);
    check({tag, "_1s"},  a1s,  1'b0);
    prev_a250 = 1'b0;
    prev_a500 = 1'b0;
    prev_a1s  = 1'b0;
  endtask

  initial begin
    int run_len;
    int hold;
    checks    = 0;
    failures  = 0;
    ka        = 0;
    kb        = 0;
    pa250     = 0;
    pa500     = 0;
    pa1s      = 0;
    prev_a250 = 1'b0;
    prev_a500 = 1'b0;
    prev_a1s  = 1'b0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;

    // Reset held for two cycles: everything stays low.
    #1;
    check("reset_a_250", a250, 1'b0);
    check("reset_a_1s",  a1s,  1'b0);
    check("reset_b_250", b250, 1'b0);
    step();
    step();

    // Release both, then run 60 edges and count pulses on instance A.
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    pa250 = 0;
    pa500 = 0;
    pa1s  = 0;
    for (int i = 0; i < 60; i++) step();
    checks++;
    assert (pa250 == 12 && pa500 == 6 && pa1s == 3)
    else begin
      failures++;
      $error("FAIL pulse_count observed=%0d/%0d/%0d expected=12/6/3",
             pa250, pa500, pa1s);
    end

    // Mid-run reset at edge 13, held three cycles.
    @(negedge clk);
    rst_a = 1'b1;
    ka    = 0;
    step();
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 13; i++) step();
    reset_a_now("midrun13");
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Reset while all three strobes are high (edge 20 just passed).
    check("pre_reset_1s_high", a1s, 1'b1);
    reset_a_now("reset_on_pulse");
    step();
    @(negedge clk);
    rst_a = 1'b0;

    // Random reset points and hold times on instance A.
    for (int r = 0; r < 10; r++) begin
      run_len = $urandom_range(1, 45);
      hold    = $urandom_range(1, 4);
      for (int i = 0; i < run_len; i++) step();
      reset_a_now("rand_reset");
      for (int i = 0; i < hold; i++) step();
      @(negedge clk);
      rst_a = 1'b0;
    end
    for (int i = 0; i < 25; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer.md
# timer

Free-running time-base generator for the fan controller. From the single 100 MHz system clock it produces three aligned, registered one-cycle strobes at 250 ms, 500 ms and 1 s intervals. Downstream blocks (speed-step sequencing, LED blink, countdown logic) use these strobes as clock enables. The block has no inputs other than clock and reset.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency in Hz.
- TICK_250MS_CYCLES, CLK_FREQ_HZ/4: clock cycles per 250 ms tick (25_000_000 at default). Benches override it to a small value. Legal range is 2 or more.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-high reset. The name is kept as the codebase uses it, but reset is asserted when the signal is 1.
- timer_250ms, output, 1: one-cycle strobe, once every TICK_250MS_CYCLES cycles.
- timer_500ms, output, 1: one-cycle strobe on every 2nd 250 ms strobe.
- timer_1s, output, 1: one-cycle strobe on every 4th 250 ms strobe.

## Operation
- Base counter cnt:
  - Width is $clog2(TICK_250MS_CYCLES).
  - Counts 0 to TICK_250MS_CYCLES-1, then wraps to 0.
  - The wrap condition is cnt == TICK_250MS_CYCLES-1.
- Quarter counter q (2 bits):
  - Increments modulo 4 on each wrap.
  - Holds otherwise.
- Strobe registers, all updated on the same edge:
  - On a wrap edge, timer_250ms <= 1.
  - On a wrap edge, timer_500ms <= (q[0] == 1).
  - On a wrap edge, timer_1s <= (q == 3).
  - On any other edge, all three strobes <= 0.
- Strobe alignment:
  - Every timer_1s pulse coincides with a timer_500ms pulse and a timer_250ms pulse.
  - Every timer_500ms pulse coincides with a timer_250ms pulse.
- Free-running: there is no enable, no load and no stop.

## Timing
- Reset value of every output is 0.
- Reset value of cnt and q is 0.
- Reset takes effect immediately and asynchronously.
- Reset while operating clears all state and the phase restarts from 0. Partial intervals are discarded, and no strobe occurs during reset.
- Let edge k be the k-th rising edge after reset is released, with k = 1 as the first. With N = TICK_250MS_CYCLES:
  - timer_250ms is high in the cycle following edges N, 2N, 3N and so on.
  - timer_500ms is high after edges 2N, 4N and so on.
  - timer_1s is high after edges 4N, 8N and so on.
- Each strobe is exactly 1 cycle wide and is never high in two consecutive cycles. This holds because N is at least 2.
- Outputs come directly from flops, with no combinational path to the outputs.
- At the default parameters:
  - Periods are exactly 25e6, 50e6 and 100e6 cycles, with zero drift.
  - The first 250 ms strobe follows 250 ms after reset release.

## Structure
- Shared package fan_pkg holds CLK_FREQ_HZ and the derived cycle constant CYCLES_250MS = CLK_FREQ_HZ/4.
- One sub-module, tick_div:
  - Parameter DIV.
  - Inputs clk, rst_n and en; output tick.
  - Produces a one-cycle pulse on every DIV-th enabled cycle.
- How timer uses tick_div:
  - One instance uses DIV=N with en=1 for the base count.
  - The quarter count is an instance with DIV=4 and en=base tick, or equivalent inline logic. All outputs are re-registered to meet the alignment rule above.

## Test plan
- Reset check, with N=5: hold reset for 2 cycles, then release. All outputs are 0 during reset and for edges 1 to 4. timer_250ms is high only after edge 5.
- Period and ratio, with N=5: run 60 cycles.
  - timer_250ms pulses after edges 5, 10, ..., 60 (12 pulses).
  - timer_500ms pulses after edges 10, 20, ..., 60 (6 pulses).
  - timer_1s pulses after edges 20, 40, 60 (3 pulses).
  - Every pulse is 1 cycle wide.
- Alignment, with N=5: at every timer_1s pulse, assert timer_500ms and timer_250ms are also 1. At every timer_500ms pulse, assert timer_250ms is also 1.
- Mid-run reset, with N=5:
  - Assert reset at edge 13 and hold it 3 cycles.
  - All outputs drop to 0 immediately.
  - After release, the next timer_250ms pulse comes 5 edges later and the next timer_1s pulse 20 edges later.
- Minimum divider, with N=2: timer_250ms toggles 0/1 every cycle pair, timer_500ms is high every 4th cycle, and timer_1s every 8th cycle.
- Default parameters: run 100_000_001 cycles. timer_1s pulses exactly once, after edge 100_000_000.
